// File: rtl/register_file_sb.sv
// register_file_sb: 2-read/1-write register file with a per-register busy scoreboard.
// Ports:
//   clk, rst (sync, active-high)
//   write_*   : writeback port, which also clears the busy bit of the written register
//   read_*    : combinational operand reads, with optional writeback bypass
//   reserve_* : issue-time destination reservation
//   busy_1/2, stall, busy_count : hazard reporting
module register_file_sb #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 3,
  parameter bit ZERO_REG   = 1'b0,
  parameter bit BYPASS     = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  write_enable,
  input  logic [ADDR_WIDTH-1:0] write_destination,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic [ADDR_WIDTH-1:0] read_address_1,
  output logic [DATA_WIDTH-1:0] read_data_1,
  input  logic [ADDR_WIDTH-1:0] read_address_2,
  output logic [DATA_WIDTH-1:0] read_data_2,
  input  logic                  reserve_enable,
  input  logic [ADDR_WIDTH-1:0] reserve_destination,
  output logic                  busy_1,
  output logic                  busy_2,
  output logic                  stall,
  output logic [ADDR_WIDTH:0]   busy_count
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0]      busy;
  logic [DEPTH-1:0]      busy_nxt;
  logic [ADDR_WIDTH:0]   count_nxt;
  logic                  wr_ok;
  logic                  rsv_ok;
  logic                  waw;

  // Writes to the hardwired zero register are dropped entirely.
  assign wr_ok = write_enable &&
                 !(ZERO_REG && write_destination == '0);

  always_comb begin
    read_data_1 = regs[read_address_1];
    busy_1      = busy[read_address_1];
    if (ZERO_REG && read_address_1 == '0) begin
      read_data_1 = '0;
      busy_1      = 1'b0;
    end else if (BYPASS && write_enable &&
                 write_destination == read_address_1) begin
      read_data_1 = write_data;
      busy_1      = 1'b0;
    end
  end

  always_comb begin
    read_data_2 = regs[read_address_2];
    busy_2      = busy[read_address_2];
    if (ZERO_REG && read_address_2 == '0) begin
      read_data_2 = '0;
      busy_2      = 1'b0;
    end else if (BYPASS && write_enable &&
                 write_destination == read_address_2) begin
      read_data_2 = write_data;
      busy_2      = 1'b0;
    end
  end

  // WAW: the destination already has a producer in flight, and that
  // producer is not retiring this cycle.
  assign waw = reserve_enable &&
               busy[reserve_destination] &&
               !(write_enable &&
                 write_destination == reserve_destination);

  assign stall = busy_1 | busy_2 | waw;

  assign rsv_ok = reserve_enable && !stall &&
                  !(ZERO_REG && reserve_destination == '0);

  // The set is applied after the clear so that a new producer issued
  // in the same cycle as a writeback to that register keeps it busy.
  always_comb begin
    busy_nxt = busy;
    if (wr_ok)
      busy_nxt[write_destination] = 1'b0;
    if (rsv_ok)
      busy_nxt[reserve_destination] = 1'b1;
  end

  always_comb begin
    count_nxt = '0;
    for (int i = 0; i < DEPTH; i++)
      count_nxt = count_nxt + (ADDR_WIDTH+1)'(busy_nxt[i]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        regs[i] <= '0;
      busy       <= '0;
      busy_count <= '0;
    end else begin
      if (wr_ok)
        regs[write_destination] <= write_data;
      busy       <= busy_nxt;
      busy_count <= count_nxt;
    end
  end

endmodule

// File: tb/tb_register_file_sb.sv
// tb_register_file_sb: directed bench for register_file_sb.
// Three instances share stimulus: default, BYPASS=0, ZERO_REG=1.
module tb_register_file_sb;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [2:0]  wd;
  logic [15:0] wdata;
  logic [2:0]  ra1;
  logic [2:0]  ra2;
  logic        re;
  logic [2:0]  rd;

  logic [15:0] d_rd1, d_rd2, n_rd1, n_rd2, z_rd1, z_rd2;
  logic        d_b1, d_b2, d_st, n_b1, n_b2, n_st, z_b1, z_b2, z_st;
  logic [3:0]  d_bc, n_bc, z_bc;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  register_file_sb u_d (
    .clk(clk), .rst(rst),
    .write_enable(we), .write_destination(wd), .write_data(wdata),
    .read_address_1(ra1), .read_data_1(d_rd1),
    .read_address_2(ra2), .read_data_2(d_rd2),
    .reserve_enable(re), .reserve_destination(rd),
    .busy_1(d_b1), .busy_2(d_b2), .stall(d_st), .busy_count(d_bc)
  );

  register_file_sb #(.BYPASS(1'b0)) u_n (
    .clk(clk), .rst(rst),
    .write_enable(we), .write_destination(wd), .write_data(wdata),
    .read_address_1(ra1), .read_data_1(n_rd1),
    .read_address_2(ra2), .read_data_2(n_rd2),
    .reserve_enable(re), .reserve_destination(rd),
    .busy_1(n_b1), .busy_2(n_b2), .stall(n_st), .busy_count(n_bc)
  );

  register_file_sb #(.ZERO_REG(1'b1)) u_z (
    .clk(clk), .rst(rst),
    .write_enable(we), .write_destination(wd), .write_data(wdata),
    .read_address_1(ra1), .read_data_1(z_rd1),
    .read_address_2(ra2), .read_data_2(z_rd2),
    .reserve_enable(re), .reserve_destination(rd),
    .busy_1(z_b1), .busy_2(z_b2), .stall(z_st), .busy_count(z_bc)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; wd = '0; wdata = '0;
    ra1 = '0; ra2 = '0; re = 1'b0; rd = '0;

    // 1: reset
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("rst_bc", 32'(d_bc), 32'd0);
    for (int a = 0; a < 8; a++) begin
      ra1 = 3'(a);
      ra2 = 3'(a);
      #1;
      check("rst_rd1", 32'(d_rd1), 32'h0);
      check("rst_rd2", 32'(d_rd2), 32'h0);
      check("rst_b1", 32'(d_b1), 32'd0);
      check("rst_b2", 32'(d_b2), 32'd0);
      check("rst_st", 32'(d_st), 32'd0);
    end

    // 2: two writes, read back
    we = 1'b1; wd = 3'd1; wdata = 16'h09A5;
    tick();
    wd = 3'd2; wdata = 16'hA357;
    tick();
    we = 1'b0; ra1 = 3'd1; ra2 = 3'd2;
    #1;
    check("wr_r1", 32'(d_rd1), 32'h09A5);
    check("wr_r2", 32'(d_rd2), 32'hA357);

    // 3: bypass vs no bypass
    we = 1'b1; wd = 3'd3; wdata = 16'h1234; ra1 = 3'd3;
    #1;
    check("byp_data", 32'(d_rd1), 32'h1234);
    check("byp_busy", 32'(d_b1), 32'd0);
    check("nobyp_old", 32'(n_rd1), 32'h0);
    tick();
    we = 1'b0;
    #1;
    check("nobyp_new", 32'(n_rd1), 32'h1234);
    check("byp_after", 32'(d_rd1), 32'h1234);

    // 4: reserve r4, then write it back
    ra1 = 3'd1; ra2 = 3'd4; re = 1'b1; rd = 3'd4;
    #1;
    check("rsv_pre_st", 32'(d_st), 32'd0);
    tick();
    re = 1'b0;
    #1;
    check("rsv_b2", 32'(d_b2), 32'd1);
    check("rsv_st", 32'(d_st), 32'd1);
    check("rsv_bc", 32'(d_bc), 32'd1);
    we = 1'b1; wd = 3'd4; wdata = 16'h00FF;
    #1;
    check("wb_b2", 32'(d_b2), 32'd0);
    check("wb_rd2", 32'(d_rd2), 32'h00FF);
    check("wb_st", 32'(d_st), 32'd0);
    check("nb_wb_b2", 32'(n_b2), 32'd1);
    tick();
    we = 1'b0;
    #1;
    check("wb_bc", 32'(d_bc), 32'd0);
    check("wb_rd2_q", 32'(d_rd2), 32'h00FF);

    // 5: WAW stall, then reserve + write same index
    ra1 = 3'd1; ra2 = 3'd2; re = 1'b1; rd = 3'd5;
    tick();
    #1;
    check("waw_st", 32'(d_st), 32'd1);
    tick();
    check("waw_bc", 32'(d_bc), 32'd1);
    check("waw_st2", 32'(d_st), 32'd1);
    we = 1'b1; wd = 3'd5; wdata = 16'h5A5A;
    #1;
    check("rw_st", 32'(d_st), 32'd0);
    tick();
    we = 1'b0; re = 1'b0; ra1 = 3'd5;
    #1;
    check("rw_data", 32'(d_rd1), 32'h5A5A);
    check("rw_b1", 32'(d_b1), 32'd1);
    check("rw_bc", 32'(d_bc), 32'd1);
    check("rw_st3", 32'(d_st), 32'd1);

    // 6: zero register (r5 is busy in u_z as well)
    ra1 = 3'd0; ra2 = 3'd0;
    we = 1'b1; wd = 3'd0; wdata = 16'hFFFF;
    re = 1'b1; rd = 3'd0;
    #1;
    check("z_byp_rd1", 32'(z_rd1), 32'h0);
    check("z_byp_b1", 32'(z_b1), 32'd0);
    check("z_st", 32'(z_st), 32'd0);
    tick();
    we = 1'b0; re = 1'b0;
    #1;
    check("z_rd1", 32'(z_rd1), 32'h0);
    check("z_rd2", 32'(z_rd2), 32'h0);
    check("z_b2", 32'(z_b2), 32'd0);
    check("z_bc", 32'(z_bc), 32'd1);
    check("d_r0_rd", 32'(d_rd1), 32'hFFFF);
    check("d_r0_b1", 32'(d_b1), 32'd1);
    check("d_r0_bc", 32'(d_bc), 32'd2);

    re = 1'b1; rd = 3'd1;
    tick();
    rd = 3'd2;
    tick();
    re = 1'b0;
    #1;
    check("z_bc3", 32'(z_bc), 32'd3);

    // reset mid-operation with pending write and reserve
    rst = 1'b1; we = 1'b1; wd = 3'd6; wdata = 16'h7777;
    re = 1'b1; rd = 3'd3;
    tick();
    rst = 1'b0; we = 1'b0; re = 1'b0;
    #1;
    check("mrst_z_bc", 32'(z_bc), 32'd0);
    check("mrst_d_bc", 32'(d_bc), 32'd0);
    for (int a = 0; a < 8; a++) begin
      ra1 = 3'(a);
      ra2 = 3'(a);
      #1;
      check("mrst_z_rd", 32'(z_rd1), 32'h0);
      check("mrst_d_rd", 32'(d_rd2), 32'h0);
      check("mrst_d_b1", 32'(d_b1), 32'd0);
      check("mrst_z_st", 32'(z_st), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/register_file_sb.md
Name: register_file_sb

Overview:
Parametrised successor to the CORG two-read/one-write register file. Adds configurable width and depth, an optional hardwired zero register, optional write-to-read bypass, and a per-register busy scoreboard for the pipelined datapath. Decode reserves a destination at issue. Writeback clears the reservation. The block reports operand hazards and a stall to the pipeline control.

Parameters:
DATA_WIDTH, 16, bits per register
ADDR_WIDTH, 3, register address bits; depth = 2**ADDR_WIDTH
ZERO_REG, 0, 1 = register 0 reads as 0, ignores writes and reservations
BYPASS, 1, 1 = same-cycle writeback data forwarded to the read ports

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  reset, synchronous, active-high
write_enable  in  1  writeback strobe
write_destination  in  ADDR_WIDTH  writeback register index
write_data  in  DATA_WIDTH  writeback data
read_address_1  in  ADDR_WIDTH  operand 1 index
read_data_1  out  DATA_WIDTH  operand 1 data (combinational)
read_address_2  in  ADDR_WIDTH  operand 2 index
read_data_2  out  DATA_WIDTH  operand 2 data (combinational)
reserve_enable  in  1  issue strobe: mark destination busy
reserve_destination  in  ADDR_WIDTH  register being reserved
busy_1  out  1  operand 1 has a pending producer
busy_2  out  1  operand 2 has a pending producer
stall  out  1  issue must hold this cycle
busy_count  out  ADDR_WIDTH+1  number of busy registers

Behaviour:
- Reset: when rst=1 at a rising edge, every register is cleared to 0 and every busy bit is cleared; busy_count=0. After reset, read_data_1/2=0, busy_1/2=0, stall=0. Reset has priority over write and reserve in the same cycle and aborts all pending reservations.
- Write: when write_enable=1 at the edge, regs[write_destination] <= write_data and busy[write_destination] <= 0. With ZERO_REG=1 and write_destination=0, the write is dropped.
- Reserve: when reserve_enable=1 and stall=0 at the edge, busy[reserve_destination] <= 1. A reservation while stall=1 is ignored. With ZERO_REG=1, reserving register 0 is ignored.
- Simultaneous reserve and write to the same index: the data is written and busy ends at 1, because the new producer wins.
- Reserve of an index that is already busy with no write to it this cycle (WAW hazard): stall=1 and busy is unchanged.
- Read N (combinational):
  - ZERO_REG=1 and address 0 -> data=0, busy=0.
  - Otherwise, if BYPASS=1, write_enable=1 and write_destination==read_address_N -> data=write_data, busy_N=0.
  - Otherwise data=regs[addr] and busy_N=busy[addr].
  - With BYPASS=0, a same-cycle write is visible only from the next cycle, and busy_N reflects the pre-edge busy bit.
- stall = busy_1 | busy_2 | (reserve_enable & WAW hazard). stall is combinational and has no latency.
- busy_count is registered: the popcount of the busy vector after each edge. It cannot exceed 2**ADDR_WIDTH, or 2**ADDR_WIDTH-1 with ZERO_REG=1.
- Latency: one cycle for write and reserve to reach state; zero for reads and hazard outputs.
- Both read ports may address the same register; both return identical data and busy.

Test Plan:
1. Reset with rst=1 for 2 cycles, then all read addresses 0..7 -> read_data=0, busy=0, stall=0, busy_count=0.
2. Write r1=16'h09A5, then write r2=16'hA357; next cycle read_address_1=1, read_address_2=2 -> read_data_1=16'h09A5, read_data_2=16'hA357.
3. BYPASS=1: write r3=16'h1234 while read_address_1=3 in the same cycle -> read_data_1=16'h1234 in that cycle with busy_1=0. Repeat with BYPASS=0 -> old value 0 in that cycle, 16'h1234 the next cycle.
4. Reserve r4 and hold read_address_2=4 -> busy_2=1, stall=1, busy_count=1. Write r4=16'h00FF -> same cycle busy_2=0 (BYPASS=1), and after the edge busy_count=0.
5. With r5 busy, set reserve_enable=1, reserve_destination=5 -> stall=1 and busy_count unchanged. Then assert write r5 and reserve r5 in the same cycle -> r5 holds the new data and stays busy, busy_count=1.
6. ZERO_REG=1: write r0=16'hFFFF and reserve r0 -> read r0=0, busy=0, busy_count unchanged. Assert rst mid-operation with 3 registers busy -> busy_count=0 and all data 0 next cycle.
